ssd1306_microcode_sequencer: RTL
================================

Name: ssd1306_microcode_sequencer

Overview:
Consumer/executor side of the SSD1306 microcode ROM interface. It drives the ROM address, fetches 10-bit microinstructions and executes them: command bytes and data bytes go to the downstream SPI byte transmitter over a valid/ready handshake, and delay instructions are timed internally. It sits between the top-level init/refresh controller (start/busy/done) and the SPI transmitter.

Parameters:
ROM_SIZE, 40, number of ROM entries; the address range is 0..ROM_SIZE-1.
DATA_WIDTH, 10, microinstruction width; fixed at 10 (2-bit opcode plus 8-bit payload).
DELAY_UNIT_CYCLES, 1000, clock cycles per delay tick; must be at least 1.
ADDRESS_BITS, $clog2(ROM_SIZE), derived local parameter; not overridable.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse that begins execution at address 0; ignored while busy=1.
busy  output  1  high from the cycle after an accepted start until done asserts.
done  output  1  sticky completion flag; cleared by the next accepted start.
rom_address  output  ADDRESS_BITS  ROM address; registered.
rom_data  input  DATA_WIDTH  ROM word (combinational from rom_address).
rom_overflow  input  1  ROM reports address>=ROM_SIZE; treated as END.
tx_data  output  8  byte to the SPI transmitter.
tx_dc  output  1  0=command, 1=data (SSD1306 D/C# line).
tx_valid  output  1  byte offered to the transmitter.
tx_ready  input  1  transmitter accepts the byte when tx_valid and tx_ready are both high.

Behaviour:
- Reset values: busy=0, done=0, rom_address=0, tx_data=0, tx_dc=0, tx_valid=0. The state machine goes to IDLE and the delay counter to 0. Reset mid-operation aborts immediately and drops tx_valid with no handshake.
- Instruction format: [9:8] opcode, [7:0] payload. Opcode 00=CMD, 01=DATA, 10=DELAY, 11=END.
- States: IDLE, FETCH, SEND, DELAY, FINISH.
- IDLE: on start → FETCH, rom_address=0, busy=1, done=0.
- FETCH (exactly 1 cycle): latch rom_data and rom_overflow into the instruction register, then decode:
  - overflow or END → FINISH.
  - CMD or DATA → SEND.
  - DELAY with payload 0 → advance.
  - DELAY with payload N>0 → DELAY, loading N*DELAY_UNIT_CYCLES (counter width sized for 255*DELAY_UNIT_CYCLES).
- SEND:
  - tx_valid=1; tx_data=payload; tx_dc=0 for CMD, 1 for DATA.
  - tx_data and tx_dc stay stable until the handshake; tx_valid never drops before it.
  - On the handshake cycle → advance; tx_valid=0 in the following cycle.
- DELAY: the counter decrements every cycle. The state lasts exactly N*DELAY_UNIT_CYCLES cycles, then → advance.
- Advance:
  - If rom_address==ROM_SIZE-1 → FINISH (end of ROM; the address never wraps).
  - Otherwise rom_address+1 → FETCH.
- FINISH (1 cycle): busy=0, done=1, rom_address=0 → IDLE.
- Throughput with tx_ready tied high: 2 cycles per CMD/DATA byte. Latency from start to first tx_valid is 2 cycles (start edge, then FETCH).
- start while busy=1 is ignored, including during FINISH. start in the same cycle FINISH sets done is ignored; done then stays 1.
- tx_ready high outside SEND has no effect.

Decomposition:
- Package ssd1306_microcode_pkg holds:
  - opcode enum (OP_CMD, OP_DATA, OP_DELAY, OP_END);
  - OPCODE_MSB/LSB and PAYLOAD_WIDTH constants;
  - sequencer state enum.
  The ROM image generator and this block share it.
- Sub-module ssd1306_delay_timer contains the load/decrement counter with a load value, a load strobe and an expired output. It is reusable by the refresh controller.

Test Plan:
- ROM [0x0AE, 0x1FF, 0x3xx], tx_ready=1, start pulse → bytes 0xAE with dc=0, then 0xFF with dc=1; 2 cycles apart; done=1 and busy=0 two cycles after the END fetch; rom_address returns to 0.
- Backpressure: tx_ready low for 5 cycles during 0x0AE → tx_valid held, tx_data=0xAE and tx_dc=0 stable for all 5 cycles; exactly one transfer.
- DELAY: 0x203 with DELAY_UNIT_CYCLES=4 → 12 cycles in DELAY, no tx_valid. 0x200 → goes straight to the next FETCH.
- No END instruction, ROM_SIZE=4, all CMD → exactly 4 bytes, then done; no address wrap, no fifth fetch.
- start pulses while busy, and start in the FINISH cycle → no restart; byte count unchanged.
- reset_n low while in SEND with tx_ready=0 → tx_valid=0, busy=0, done=0 and rom_address=0 immediately (asynchronously). A new start after reset restarts at address 0.

Source files
------------

// File: rtl/ssd1306_microcode_pkg.sv
// Shared definitions for the SSD1306 microcode format: opcodes, field positions
// and the sequencer state encoding. Also used by the ROM image generator.
package ssd1306_microcode_pkg;

  localparam int INSTR_WIDTH   = 10;
  localparam int OPCODE_MSB    = 9;
  localparam int OPCODE_LSB    = 8;
  localparam int PAYLOAD_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_DELAY,
    ST_FINISH
  } seq_state_e;

  function automatic opcode_e instr_opcode(input logic [INSTR_WIDTH-1:0] instr);
    return opcode_e'(instr[OPCODE_MSB:OPCODE_LSB]);
  endfunction

  function automatic logic [PAYLOAD_WIDTH-1:0] instr_payload(input logic [INSTR_WIDTH-1:0] instr);
    return instr[PAYLOAD_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ssd1306_delay_timer.sv
// Load/decrement interval timer. expired is high during the final cycle of the
// loaded interval, so a caller that leaves on expired spends exactly load_value cycles.
module ssd1306_delay_timer #(
  parameter int COUNT_WIDTH = 18
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   enable,
  output logic                   expired
);

  logic [COUNT_WIDTH-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - COUNT_WIDTH'(1);
    end
  end

  assign expired = (count == COUNT_WIDTH'(1));

endmodule

// File: rtl/ssd1306_microcode_sequencer.sv
// Fetches 10-bit microinstructions from the init/refresh ROM and executes them:
// CMD/DATA bytes go to the SPI transmitter, DELAY instructions are timed locally.
module ssd1306_microcode_sequencer
  import ssd1306_microcode_pkg::*;
#(
  parameter  int ROM_SIZE          = 40,
  parameter  int DATA_WIDTH        = 10,
  parameter  int DELAY_UNIT_CYCLES = 1000,
  localparam int ADDRESS_BITS      = $clog2(ROM_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDRESS_BITS-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  input  logic                    rom_overflow,
  output logic [7:0]              tx_data,
  output logic                    tx_dc,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  localparam int COUNT_WIDTH = $clog2(255 * DELAY_UNIT_CYCLES + 1);
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDRESS = ADDRESS_BITS'(ROM_SIZE - 1);

  seq_state_e              state, state_next;
  logic [ADDRESS_BITS-1:0] address_next;
  logic [DATA_WIDTH-1:0]   instr_q, instr_next;
  logic                    busy_next, done_next, valid_next;
  logic                    advance, timer_load, timer_expired;
  opcode_e                 fetch_op;
  logic [7:0]              fetch_payload;
  logic [COUNT_WIDTH-1:0]  delay_cycles;

  assign fetch_op      = instr_opcode(rom_data);
  assign fetch_payload = instr_payload(rom_data);
  assign delay_cycles  = COUNT_WIDTH'(fetch_payload) * COUNT_WIDTH'(DELAY_UNIT_CYCLES);

  // The byte on offer comes straight from the instruction register, which only
  // changes in FETCH, so tx_data/tx_dc hold steady for the whole handshake.
  assign tx_data = instr_payload(instr_q);
  assign tx_dc   = (instr_opcode(instr_q) == OP_DATA);

  ssd1306_delay_timer #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_delay_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (delay_cycles),
    .enable     (state == ST_DELAY),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rom_address <= '0;
      instr_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_valid    <= 1'b0;
    end else begin
      state       <= state_next;
      rom_address <= address_next;
      instr_q     <= instr_next;
      busy        <= busy_next;
      done        <= done_next;
      tx_valid    <= valid_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_next   = state;
    address_next = rom_address;
    instr_next   = instr_q;
    busy_next    = busy;
    done_next    = done;
    valid_next   = tx_valid;
    advance      = 1'b0;
    timer_load   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_FETCH;
          address_next = '0;
          busy_next    = 1'b1;
          done_next    = 1'b0;
        end
      end
      ST_FETCH: begin
        instr_next = rom_data;
        if (rom_overflow || fetch_op == OP_END) begin
          state_next = ST_FINISH;
        end else if (fetch_op == OP_DELAY) begin
          if (fetch_payload == 8'd0) begin
            advance = 1'b1;
          end else begin
            timer_load = 1'b1;
            state_next = ST_DELAY;
          end
        end else begin
          state_next = ST_SEND;
          valid_next = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          valid_next = 1'b0;
          advance    = 1'b1;
        end
      end
      ST_DELAY: begin
        if (timer_expired) advance = 1'b1;
      end
      ST_FINISH: begin
        state_next   = ST_IDLE;
        address_next = '0;
        busy_next    = 1'b0;
        done_next    = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    // End of ROM finishes instead of wrapping back to address 0.
    if (advance) begin
      if (rom_address == LAST_ADDRESS) begin
        state_next = ST_FINISH;
      end else begin
        state_next   = ST_FETCH;
        address_next = rom_address + ADDRESS_BITS'(1);
      end
    end
  end

endmodule
